// File: rtl/pc_next_unit.sv
// Program counter register and next-PC selection for the RISC-V fetch stage.
// Handles sequential step, branch/JAL, JALR, trap redirect and stall-buffered redirects.
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              STEP         = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jalr,
  input  logic            flush,
  input  logic [XLEN-1:0] imm_val,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_step,
  output logic [XLEN-1:0] target_addr,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic            pending
);

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 2) ? XLEN'(1) : XLEN'(3);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic            fetch_valid_q;
  logic            misaligned_q;
  logic            pending_q;

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_req;
  logic            tgt_misaligned;

  // Redirect requests are single-cycle levels sampled at the clock edge; there is
  // no ready back-pressure, so the issuer must hold off while pending is high.
  always_comb begin
    jalr_sum       = rs1_val + imm_val;
    redirect_tgt   = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_val);
    redirect_req   = jalr | branch_taken;
    tgt_misaligned = |(redirect_tgt & ALIGN_MASK);
  end

  assign pc_plus_step = pc_q + XLEN'(STEP);
  assign target_addr  = flush ? trap_vector : redirect_tgt;
  assign pc_out       = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign misaligned   = misaligned_q;
  assign pending      = pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      pend_tgt_q    <= '0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b1;
      misaligned_q  <= 1'b0;
      if (flush) begin
        pc_q      <= trap_vector;
        pending_q <= 1'b0;
      end else if (stall) begin
        if (redirect_req) begin
          if (tgt_misaligned) begin
            misaligned_q <= 1'b1;
          end else begin
            pend_tgt_q <= redirect_tgt;
            pending_q  <= 1'b1;
          end
        end
      end else if (pending_q) begin
        pc_q      <= pend_tgt_q;
        pending_q <= 1'b0;
      end else if (redirect_req) begin
        if (tgt_misaligned) begin
          misaligned_q <= 1'b1;
        end else begin
          pc_q <= redirect_tgt;
        end
      end else if (fetch_valid_q) begin
        // The reset vector itself must be fetched once, so the first post-reset edge holds.
        pc_q <= pc_plus_step;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus randomized traffic against a
// rule-level reference model, on an IALIGN=4 and an IALIGN=2 instance side by side.
module tb_pc_next_unit;

  logic        clk;
  logic        reset, stall, branch_taken, jalr, flush;
  logic [31:0] imm_val, rs1_val, trap_vector;

  logic [31:0] pc4, pps4, tgt4;
  logic        fv4, mis4, pend4;
  logic [31:0] pc2, pps2, tgt2;
  logic        fv2, mis2, pend2;

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = IALIGN 4, index 1 = IALIGN 2
  logic [31:0] m_pc[2];
  logic [31:0] m_ptgt[2];
  logic        m_fv[2], m_mis[2], m_pend[2];

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .STEP(4)) u4 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken), .jalr(jalr),
    .flush(flush), .imm_val(imm_val), .rs1_val(rs1_val), .trap_vector(trap_vector),
    .pc_out(pc4), .pc_plus_step(pps4), .target_addr(tgt4), .fetch_valid(fv4),
    .misaligned(mis4), .pending(pend4));

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2), .STEP(4)) u2 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken), .jalr(jalr),
    .flush(flush), .imm_val(imm_val), .rs1_val(rs1_val), .trap_vector(trap_vector),
    .pc_out(pc2), .pc_plus_step(pps2), .target_addr(tgt2), .fetch_valid(fv2),
    .misaligned(mis2), .pending(pend2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jalr = 0; flush = 0;
    imm_val = 0; rs1_val = 0; trap_vector = 0;
  endtask

  task automatic go_to(input logic [31:0] addr);
    clear_inputs();
    flush = 1; trap_vector = addr;
    tick();
    flush = 0;
  endtask

  // reference model: one clock edge of the documented priority rules
  task automatic model_edge(input int k);
    logic [31:0] tgt;
    logic        req, bad;
    logic [31:0] align;
    align = (k == 0) ? 32'd4 : 32'd2;
    req   = branch_taken | jalr;
    if (jalr) tgt = (rs1_val + imm_val) & 32'hFFFF_FFFE;
    else      tgt = m_pc[k] + imm_val;
    bad = req && ((tgt % align) != 0);
    m_mis[k] = 0;
    if (reset) begin
      m_pc[k] = 32'h0; m_fv[k] = 0; m_pend[k] = 0; m_ptgt[k] = 0;
    end else begin
      if (flush) begin
        m_pc[k] = trap_vector; m_pend[k] = 0;
      end else if (stall) begin
        if (bad) m_mis[k] = 1;
        else if (req) begin m_ptgt[k] = tgt; m_pend[k] = 1; end
      end else if (m_pend[k]) begin
        m_pc[k] = m_ptgt[k]; m_pend[k] = 0;
      end else if (bad) begin
        m_mis[k] = 1;
      end else if (req) begin
        m_pc[k] = tgt;
      end else if (m_fv[k]) begin
        m_pc[k] = m_pc[k] + 32'd4;
      end
      m_fv[k] = 1;
    end
  endtask

  function automatic logic [31:0] model_target(input int k);
    if (flush) return trap_vector;
    if (jalr)  return (rs1_val + imm_val) & 32'hFFFF_FFFE;
    return m_pc[k] + imm_val;
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    n_checks++; if (pc4 !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h exp %h", pc4, 32'h0); end
    n_checks++; if (fv4 !== 1'b0) begin n_errors++; $display("FAIL reset_fetch_valid: got %b exp 0", fv4); end
    n_checks++; if (pend4 !== 1'b0 || mis4 !== 1'b0) begin n_errors++; $display("FAIL reset_flags: pend %b mis %b exp 0 0", pend4, mis4); end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (pc4 !== 32'(i * 4)) begin n_errors++; $display("FAIL release_pc%0d: got %h exp %h", i, pc4, 32'(i * 4)); end
      n_checks++; if (fv4 !== 1'b1) begin n_errors++; $display("FAIL release_fv%0d: got %b exp 1", i, fv4); end
    end
  endtask

  task automatic test_branch();
    go_to(32'h0000_0100);
    branch_taken = 1; imm_val = 32'hFFFF_FFF0;
    #1;
    n_checks++; if (tgt4 !== 32'h0000_00F0) begin n_errors++; $display("FAIL branch_target: got %h exp %h", tgt4, 32'h0000_00F0); end
    tick();
    branch_taken = 0;
    n_checks++; if (pc4 !== 32'h0000_00F0) begin n_errors++; $display("FAIL branch_pc: got %h exp %h", pc4, 32'h0000_00F0); end
  endtask

  task automatic test_jalr();
    go_to(32'h0000_0200);
    jalr = 1; rs1_val = 32'h0000_1001; imm_val = 32'h0000_0004;
    #1;
    n_checks++; if (pps4 !== 32'h0000_0204) begin n_errors++; $display("FAIL jalr_link: got %h exp %h", pps4, 32'h0000_0204); end
    n_checks++; if (tgt4 !== 32'h0000_1004) begin n_errors++; $display("FAIL jalr_target: got %h exp %h", tgt4, 32'h0000_1004); end
    tick();
    jalr = 0;
    n_checks++; if (pc4 !== 32'h0000_1004) begin n_errors++; $display("FAIL jalr_pc: got %h exp %h", pc4, 32'h0000_1004); end
  endtask

  task automatic test_stalled_redirect();
    go_to(32'h0000_0040);
    stall = 1; branch_taken = 1; imm_val = 32'h0000_0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      branch_taken = 0;
      n_checks++; if (pend4 !== 1'b1 || pc4 !== 32'h0000_0040) begin n_errors++; $display("FAIL stall_hold%0d: pend %b pc %h exp 1 00000040", i, pend4, pc4); end
    end
    stall = 0;
    tick();
    n_checks++; if (pc4 !== 32'h0000_0060 || pend4 !== 1'b0) begin n_errors++; $display("FAIL stall_apply: pc %h pend %b exp 00000060 0", pc4, pend4); end
    go_to(32'h0000_0040);
    stall = 1; branch_taken = 1; imm_val = 32'h0000_0020;
    tick();
    branch_taken = 0;
    tick();
    flush = 1; trap_vector = 32'h0000_0800;
    tick();
    flush = 0; stall = 0;
    n_checks++; if (pc4 !== 32'h0000_0800 || pend4 !== 1'b0) begin n_errors++; $display("FAIL stall_flush: pc %h pend %b exp 00000800 0", pc4, pend4); end
    tick();
    n_checks++; if (pc4 !== 32'h0000_0804) begin n_errors++; $display("FAIL stall_flush_discard: got %h exp %h", pc4, 32'h0000_0804); end
  endtask

  task automatic test_misaligned();
    go_to(32'h0000_0010);
    branch_taken = 1; imm_val = 32'h0000_0006;
    tick();
    branch_taken = 0;
    n_checks++; if (pc4 !== 32'h0000_0010 || mis4 !== 1'b1) begin n_errors++; $display("FAIL mis4_pulse: pc %h mis %b exp 00000010 1", pc4, mis4); end
    n_checks++; if (pc2 !== 32'h0000_0016 || mis2 !== 1'b0) begin n_errors++; $display("FAIL mis2_taken: pc %h mis %b exp 00000016 0", pc2, mis2); end
    tick();
    n_checks++; if (mis4 !== 1'b0 || pc4 !== 32'h0000_0014) begin n_errors++; $display("FAIL mis4_clear: pc %h mis %b exp 00000014 0", pc4, mis4); end
    // misaligned request while stalled must not be buffered
    stall = 1; branch_taken = 1; imm_val = 32'h0000_0002;
    tick();
    branch_taken = 0;
    n_checks++; if (mis4 !== 1'b1 || pend4 !== 1'b0) begin n_errors++; $display("FAIL mis4_stalled: mis %b pend %b exp 1 0", mis4, pend4); end
    n_checks++; if (pend2 !== 1'b1) begin n_errors++; $display("FAIL mis2_stalled_pend: got %b exp 1", pend2); end
    stall = 0;
    tick();
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFC);
    #1;
    n_checks++; if (pps4 !== 32'h0) begin n_errors++; $display("FAIL wrap_link: got %h exp %h", pps4, 32'h0); end
    tick();
    n_checks++; if (pc4 !== 32'h0) begin n_errors++; $display("FAIL wrap_pc: got %h exp %h", pc4, 32'h0); end
  endtask

  task automatic test_reset_mid_stall();
    go_to(32'h0000_0040);
    stall = 1; branch_taken = 1; imm_val = 32'h0000_0020;
    tick();
    branch_taken = 0;
    n_checks++; if (pend4 !== 1'b1) begin n_errors++; $display("FAIL rst_stall_pend: got %b exp 1", pend4); end
    reset = 1;
    tick();
    n_checks++; if (pc4 !== 32'h0 || pend4 !== 1'b0 || fv4 !== 1'b0) begin n_errors++; $display("FAIL rst_stall_state: pc %h pend %b fv %b exp 0 0 0", pc4, pend4, fv4); end
    reset = 0; stall = 0;
    tick();
    n_checks++; if (pc4 !== 32'h0 || fv4 !== 1'b1 || pend4 !== 1'b0) begin n_errors++; $display("FAIL rst_stall_release: pc %h fv %b pend %b exp 0 1 0", pc4, fv4, pend4); end
  endtask

  task automatic test_random();
    int r;
    go_to(32'h0000_1000);
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0000_1000; m_fv[k] = 1; m_pend[k] = 0; m_mis[k] = 0; m_ptgt[k] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 7);
      if (!m_pend[0] && !m_pend[1]) begin
        branch_taken = (r == 0 || r == 1 || r == 3);
        jalr         = (r == 2 || r == 3);
      end
      imm_val = $urandom_range(0, 64);
      imm_val = imm_val - 32'd32;
      if ($urandom_range(0, 3) != 0) imm_val = imm_val & 32'hFFFF_FFFC;
      rs1_val = $urandom;
      if ($urandom_range(0, 1) == 0) rs1_val = rs1_val & 32'hFFFF_FFFC;
      trap_vector = $urandom & 32'hFFFF_FFFC;
      #1;
      n_checks++; if (tgt4 !== model_target(0) || tgt2 !== model_target(1)) begin n_errors++; $display("FAIL rnd_target@%0d: got %h/%h exp %h/%h", cyc, tgt4, tgt2, model_target(0), model_target(1)); end
      n_checks++; if (pps4 !== m_pc[0] + 32'd4 || pps2 !== m_pc[1] + 32'd4) begin n_errors++; $display("FAIL rnd_link@%0d: got %h/%h exp %h/%h", cyc, pps4, pps2, m_pc[0] + 32'd4, m_pc[1] + 32'd4); end
      model_edge(0);
      model_edge(1);
      tick();
      n_checks++; if (pc4 !== m_pc[0] || fv4 !== m_fv[0] || pend4 !== m_pend[0] || mis4 !== m_mis[0]) begin n_errors++; $display("FAIL rnd_state4@%0d: pc %h fv %b pend %b mis %b exp %h %b %b %b", cyc, pc4, fv4, pend4, mis4, m_pc[0], m_fv[0], m_pend[0], m_mis[0]); end
      n_checks++; if (pc2 !== m_pc[1] || fv2 !== m_fv[1] || pend2 !== m_pend[1] || mis2 !== m_mis[1]) begin n_errors++; $display("FAIL rnd_state2@%0d: pc %h fv %b pend %b mis %b exp %h %b %b %b", cyc, pc2, fv2, pend2, mis2, m_pc[1], m_fv[1], m_pend[1], m_mis[1]); end
    end
    clear_inputs();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_branch();
    test_jalr();
    test_stalled_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised next-PC generator for the RISC-V core: holds the program counter register and computes the sequential, branch/JAL, JALR and trap-redirect next address.
- Generalises the plain PC+immediate adder in four ways: configurable width, configurable reset vector and instruction alignment, a registered pending-redirect buffer that survives stalls, and misalignment detection.
- Sits between the fetch stage (consumes pc_out and fetch_valid) and execute/trap logic (drives the redirect requests).

Parameters:
XLEN, 32, datapath/address width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; XLEN bits.
IALIGN, 4, instruction alignment in bytes; only 2 or 4 are legal.
STEP, 4, sequential increment in bytes.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold the PC; fetch not accepting.
branch_taken  input  1  redirect to pc_out + imm_val (branch/JAL).
jalr  input  1  redirect to (rs1_val + imm_val) with bit 0 cleared.
flush  input  1  trap/exception redirect to trap_vector.
imm_val  input  XLEN  sign-extended immediate.
rs1_val  input  XLEN  JALR base register value.
trap_vector  input  XLEN  trap handler address.
pc_out  output  XLEN  current PC (registered).
pc_plus_step  output  XLEN  pc_out + STEP (combinational; JAL/JALR link value).
target_addr  output  XLEN  combinational target for the currently selected redirect.
fetch_valid  output  1  pc_out is a valid fetch address (registered).
misaligned  output  1  one-cycle pulse: a redirect target violated IALIGN (registered).
pending  output  1  a redirect is buffered while stalled (registered).

Behaviour:
- All arithmetic is modulo 2^XLEN; carry is discarded. Example: FFFF_FFFC + 4 wraps to 0000_0000.
- target_addr is combinational:
  - rs1_val + imm_val with bit 0 forced to 0 when jalr=1;
  - otherwise pc_out + imm_val;
  - trap_vector when flush=1.
- Misaligned target:
  - IALIGN=4: target_addr[1:0] != 0.
  - IALIGN=2: target_addr[0] != 0 (never true for JALR).
  - flush targets are never checked.
- Reset (synchronous, active-high): pc_out=RESET_VECTOR, fetch_valid=0, misaligned=0, pending=0, pending target register=0.
- fetch_valid rises to 1 on the first clock edge after reset is deasserted.
- Update priority at each rising edge, highest first:
  1. reset.
  2. flush: pc_out<=trap_vector; pending cleared; fetch_valid<=1. Ignores stall.
  3. stall=1 with a new branch_taken or jalr:
     - aligned target: captured into the pending register, pending<=1, pc_out holds;
     - misaligned target: misaligned pulses, nothing is captured.
  4. stall=1 otherwise: pc_out holds; pending holds.
  5. stall=0 and pending=1: pc_out<=pending target; pending<=0. A new request in the same cycle is ignored; the issuer must not issue one while pending=1.
  6. stall=0 with jalr or branch_taken (jalr wins if both asserted):
     - aligned target: pc_out<=target_addr;
     - misaligned target: pc_out holds and misaligned<=1 for exactly one cycle. Trap logic is expected to follow with flush.
  7. Otherwise: pc_out<=pc_out+STEP.
- Redirect latency: target appears on pc_out one cycle after the request edge (registered, zero bubbles).
- The pending redirect holds for any number of stalled cycles and is applied on the first stall=0 edge.
- A pending redirect is discarded by flush or reset.
- misaligned deasserts the following cycle unless re-triggered.

Test Plan:
- Reset release: reset=1 for 2 cycles, then 0, no requests → pc_out=0000_0000 (fetch_valid=0) during reset; fetch_valid=1 from the first post-reset edge; pc_out advances 0, 4, 8, C on successive edges.
- Branch: pc_out=0000_0100, branch_taken=1, imm_val=FFFF_FFF0 → next edge pc_out=0000_00F0; target_addr=0000_00F0 while requested.
- JALR plus link: pc_out=0000_0200, jalr=1, rs1_val=0000_1001, imm_val=0000_0004 → pc_plus_step=0000_0204; next pc_out=0000_1004 (bit 0 cleared).
- Stalled redirect: pc_out=0000_0040, stall=1, branch_taken=1, imm_val=0000_0020 for 1 cycle, stall held 3 cycles → pending=1 and pc_out=0000_0040 throughout; stall drops → pc_out=0000_0060, pending=0. Repeat with flush (trap_vector=0000_0800) during the stall → pc_out=0000_0800, pending=0.
- Misaligned, IALIGN=4: pc_out=0000_0010, branch_taken=1, imm_val=0000_0006 → pc_out stays 0000_0010, misaligned=1 for exactly 1 cycle. With IALIGN=2 the same stimulus → pc_out=0000_0016, misaligned=0.
- Wrap and reset mid-stall: pc_out=FFFF_FFFC, no requests → pc_out=0000_0000. Separately, pending=1 and reset=1 → pc_out=RESET_VECTOR, pending=0, fetch_valid=0.
